// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data types, packet header layout, CRC constants
// and the 6-bit header ECC. The ECC function is also used by the RX side.
package csi2_pkg;

   localparam logic [5:0]  DT_FS    = 6'h00;
   localparam logic [5:0]  DT_FE    = 6'h01;
   localparam logic [5:0]  DT_RAW10 = 6'h2B;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h8408;

   typedef struct packed {
      logic [7:0]  ecc;
      logic [15:0] wc;
      logic [7:0]  di;
   } csi2_hdr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FS,
      ST_HDR,
      ST_PAY,
      ST_PAD,
      ST_DROP,
      ST_CRC,
      ST_FE
   } tx_state_t;

   // d[7:0] = DI, d[23:8] = WC; parity bit p[n] covers the data bits of set n.
   function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

   function automatic csi2_hdr_t csi2_make_hdr(input logic [1:0] vc, input logic [5:0] dt,
                                               input logic [15:0] wc);
      csi2_hdr_t h;
      h.di  = {vc, dt};
      h.wc  = wc;
      h.ecc = {2'b00, csi2_ecc({wc, vc, dt})};
      return h;
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle used for both the video input and packet output.
interface axi4_stream_if #(
   parameter int DW = 32
) ();
   logic [DW-1:0]   tdata;
   logic [DW/8-1:0] tstrb;
   logic            tvalid;
   logic            tready;
   logic            tlast;
   logic            tuser;

   modport master (output tdata, tstrb, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tstrb, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/csi2_crc16_32b.sv
// Combinational next-CRC (reflected CCITT, poly 0x8408) over one 32-bit word;
// enabled bytes are folded in order 0..3, each LSB first.
module csi2_crc16_32b
   import csi2_pkg::*;
(
   input  logic [15:0] i_crc,
   input  logic [31:0] i_data,
   input  logic [3:0]  i_byte_en,
   output logic [15:0] o_crc
);

   logic [15:0] w_c;

   always_comb begin
      w_c = i_crc;
      for (int b = 0; b < 4; b++) begin
         if (i_byte_en[b]) begin
            w_c = w_c ^ {8'h00, i_data[8*b +: 8]};
            for (int k = 0; k < 8; k++) begin
               w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
            end
         end
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/csi2_tx_pkt_builder.sv
// CSI-2 TX packetizer: FS, per-line long packets (header, payload, CRC), FE.
// Optional frame numbering in FS/FE WC under `CSI2_TX_FRAME_CNT_EN.
//
// state   | meaning
// IDLE    | wait for enabled SOF; stray non-SOF words are dropped
// FS      | emit frame-start short packet
// HDR     | emit long-packet header, reset CRC and word count
// PAY     | pass payload words through the output register
// PAD     | input line ended early; emit zero words up to WC
// DROP    | line too long; swallow input until tlast
// CRC     | emit CRC word, count the line
// FE      | emit frame-end short packet
module csi2_tx_pkt_builder
   import csi2_pkg::*;
#(
   parameter logic [1:0] VC             = 2'd0,
   parameter logic [5:0] DATA_TYPE      = DT_RAW10,
   parameter int         MAX_LINE_BYTES = 8192
) (
   input  logic          clk_i,
   input  logic          srst_i,
   input  logic          enable_i,
   input  logic [15:0]   line_bytes_i,
   input  logic [15:0]   frame_lines_i,
   axi4_stream_if.slave  video_i,
   axi4_stream_if.master pkt_o,
   output logic          len_err_o,
   output logic          busy_o
);

   localparam int WCW = $clog2(MAX_LINE_BYTES / 4 + 1);

   tx_state_t        r_state, w_state_nxt;
   logic             r_tvalid, r_tlast, r_len_err;
   logic [3:0]       r_tstrb;
   logic [31:0]      r_tdata;
   logic [15:0]      r_crc, r_wc, r_lines_left;
   logic [WCW-1:0]   r_words_left;

   logic             w_load, w_emit, w_last, w_vid_ready, w_len_err;
   logic             w_start, w_hdr, w_pay, w_line_done;
   logic [3:0]       w_strb;
   logic [31:0]      w_word, w_crc_data;
   logic [15:0]      w_crc_nxt, w_short_wc;
   csi2_hdr_t        w_fs_hdr, w_fe_hdr, w_long_hdr;
   logic             w_unused;

   assign w_unused   = ^video_i.tstrb;
   assign w_load     = !r_tvalid || pkt_o.tready;
   assign w_fs_hdr   = csi2_make_hdr(VC, DT_FS, w_short_wc);
   assign w_fe_hdr   = csi2_make_hdr(VC, DT_FE, w_short_wc);
   assign w_long_hdr = csi2_make_hdr(VC, DATA_TYPE, r_wc);

   csi2_crc16_32b u_crc (
      .i_crc     (r_crc),
      .i_data    (w_crc_data),
      .i_byte_en (4'hF),
      .o_crc     (w_crc_nxt)
   );

   always_ff @(posedge clk_i) begin
      if (srst_i) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_word      = 32'h0;
      w_strb      = 4'hF;
      w_last      = 1'b0;
      w_vid_ready = 1'b0;
      w_len_err   = 1'b0;
      w_start     = 1'b0;
      w_hdr       = 1'b0;
      w_pay       = 1'b0;
      w_line_done = 1'b0;
      w_crc_data  = 32'h0;
      case (r_state)
         ST_IDLE: begin
            w_vid_ready = video_i.tvalid && !video_i.tuser;
            if (enable_i && video_i.tvalid && video_i.tuser) begin
               w_start     = 1'b1;
               w_state_nxt = ST_FS;
            end
         end
         ST_FS: begin
            if (w_load) begin
               w_emit      = 1'b1;
               w_word      = w_fs_hdr;
               w_last      = 1'b1;
               w_state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            if (w_load) begin
               w_emit      = 1'b1;
               w_word      = w_long_hdr;
               w_hdr       = 1'b1;
               w_state_nxt = ST_PAY;
            end
         end
         ST_PAY: begin
            w_vid_ready = w_load;
            if (w_load && video_i.tvalid) begin
               w_emit     = 1'b1;
               w_word     = video_i.tdata;
               w_crc_data = video_i.tdata;
               w_pay      = 1'b1;
               if (r_words_left == WCW'(1)) begin
                  w_len_err   = !video_i.tlast;
                  w_state_nxt = video_i.tlast ? ST_CRC : ST_DROP;
               end else if (video_i.tlast) begin
                  w_len_err   = 1'b1;
                  w_state_nxt = ST_PAD;
               end
            end
         end
         ST_PAD: begin
            if (w_load) begin
               w_emit = 1'b1;
               w_pay  = 1'b1;
               if (r_words_left == WCW'(1)) w_state_nxt = ST_CRC;
            end
         end
         ST_DROP: begin
            w_vid_ready = 1'b1;
            if (video_i.tvalid && video_i.tlast) w_state_nxt = ST_CRC;
         end
         ST_CRC: begin
            if (w_load) begin
               w_emit      = 1'b1;
               w_word      = {16'h0, r_crc};
               w_strb      = 4'b0011;
               w_last      = 1'b1;
               w_line_done = 1'b1;
               w_state_nxt = (r_lines_left == 16'd1) ? ST_FE : ST_HDR;
            end
         end
         ST_FE: begin
            if (w_load) begin
               w_emit      = 1'b1;
               w_word      = w_fe_hdr;
               w_last      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_tvalid     <= 1'b0;
         r_tdata      <= 32'h0;
         r_tstrb      <= 4'h0;
         r_tlast      <= 1'b0;
         r_len_err    <= 1'b0;
         r_crc        <= CRC_INIT;
         r_wc         <= 16'h0;
         r_lines_left <= 16'h0;
         r_words_left <= '0;
      end else begin
         if (w_load) begin
            r_tvalid <= w_emit;
            if (w_emit) begin
               r_tdata <= w_word;
               r_tstrb <= w_strb;
               r_tlast <= w_last;
            end
         end
         if (w_start) begin
            r_wc         <= line_bytes_i;
            r_lines_left <= frame_lines_i;
         end
         if (w_hdr) begin
            r_crc        <= CRC_INIT;
            r_words_left <= r_wc[WCW+1:2];
         end
         if (w_pay) begin
            r_crc        <= w_crc_nxt;
            r_words_left <= r_words_left - WCW'(1);
         end
         if (w_line_done) r_lines_left <= r_lines_left - 16'd1;
         r_len_err <= w_len_err;
      end
   end

`ifdef CSI2_TX_FRAME_CNT_EN
   // Numbering skips 0 on wrap; FE reuses the FS number since it advances on FE.
   logic [15:0] r_frame_num;
   always_ff @(posedge clk_i) begin
      if (srst_i) r_frame_num <= 16'd1;
      else if ((r_state == ST_FE) && w_load)
         r_frame_num <= (r_frame_num == 16'hFFFF) ? 16'd1 : r_frame_num + 16'd1;
   end
   assign w_short_wc = r_frame_num;
`else
   assign w_short_wc = 16'h0;
`endif

   assign video_i.tready = w_vid_ready;
   assign pkt_o.tvalid   = r_tvalid;
   assign pkt_o.tdata    = r_tdata;
   assign pkt_o.tstrb    = r_tstrb;
   assign pkt_o.tlast    = r_tlast;
   assign pkt_o.tuser    = 1'b0;
   assign len_err_o      = r_len_err;
   assign busy_o         = (r_state != ST_IDLE) || r_tvalid;

endmodule

// File: tb/tb_csi2_tx_pkt_builder.sv
// Self-checking bench for csi2_tx_pkt_builder: frame vector table plus
// hand-written corner sequences, checked against a queue of expected words.
module tb_csi2_tx_pkt_builder;
   import csi2_pkg::*;

   logic        clk = 1'b0;
   logic        srst, enable, len_err, busy;
   logic [15:0] line_bytes, frame_lines;

   axi4_stream_if #(.DW(32)) vid ();
   axi4_stream_if #(.DW(32)) pkt ();

   csi2_tx_pkt_builder dut (
      .clk_i         (clk),
      .srst_i        (srst),
      .enable_i      (enable),
      .line_bytes_i  (line_bytes),
      .frame_lines_i (frame_lines),
      .video_i       (vid),
      .pkt_o         (pkt),
      .len_err_o     (len_err),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } exp_t;

   typedef struct {
      int lb;
      int fl;
      int nin;
      bit rnd;
      int exp_err;
   } vec_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          err_pulses = 0;
   int          exp_fnum = 1;
   bit          mon_en = 0;
   bit          rnd_ready = 0;
   bit          stall_prev = 0;
   logic [63:0] stall_word;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [5:0] ecc_m(input logic [23:0] d);
      return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
              ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
   endfunction

   function automatic logic [31:0] hdr_m(input logic [5:0] dt, input logic [15:0] wc);
      logic [7:0] di;
      di = {2'b00, dt};
      return {2'b00, ecc_m({wc, di}), wc, di};
   endfunction

   function automatic logic [15:0] crc_m(input logic [15:0] c_in, input logic [31:0] w);
      logic [15:0] c;
      logic        fb;
      c = c_in;
      for (int i = 0; i < 32; i++) begin
         fb = c[0] ^ w[i];
         c  = c >> 1;
         if (fb) c = c ^ 16'h8408;
      end
      return c;
   endfunction

   function automatic logic [15:0] short_wc();
`ifdef CSI2_TX_FRAME_CNT_EN
      return exp_fnum[15:0];
`else
      return 16'h0;
`endif
   endfunction

   task automatic push(input logic [31:0] d, input logic [3:0] s, input logic l);
      exp_t e;
      e.data = d; e.strb = s; e.last = l;
      q.push_back(e);
   endtask

   // Packet-side monitor: compares every accepted word, checks stall stability.
   always @(negedge clk) begin
      if (mon_en && !srst) begin
         if (stall_prev)
            chk("stall_hold", {26'h0, pkt.tvalid, pkt.tlast, pkt.tstrb, pkt.tdata}, stall_word);
         if (pkt.tvalid && pkt.tready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: got %h, expected no output", pkt.tdata);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("pkt_word", {27'h0, pkt.tlast, pkt.tstrb, pkt.tdata},
                   {27'h0, e.last, e.strb, e.data});
            end
         end
         stall_prev = pkt.tvalid && !pkt.tready;
         stall_word = {26'h0, pkt.tvalid, pkt.tlast, pkt.tstrb, pkt.tdata};
         if (len_err) err_pulses++;
      end else begin
         stall_prev = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      pkt.tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   task automatic drive_word(input logic [31:0] d, input logic u, input logic l);
      bit ok;
      ok = 0;
      vid.tdata  = d;
      vid.tuser  = u;
      vid.tlast  = l;
      vid.tvalid = 1'b1;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (vid.tready) begin
            ok = 1;
            @(posedge clk);
            #1;
         end
      end
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL drive_timeout: word %h not accepted, expected accept within 400 cycles", d);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
      chk("drain_left", q.size(), 0);
      repeat (3) @(negedge clk);
      chk("busy_after_fe", busy, 0);
   endtask

   task automatic run_frame(input int lb, input int fl, input int nin, input bit rnd,
                            input int exp_err);
      logic [31:0] dq[$];
      logic [31:0] w;
      logic [15:0] c;
      int          wcw;
      wcw         = lb / 4;
      @(posedge clk);
      #2;
      rnd_ready   = rnd;
      enable      = 1'b1;
      line_bytes  = 16'(lb);
      frame_lines = 16'(fl);
      err_pulses  = 0;
      push(hdr_m(DT_FS, short_wc()), 4'hF, 1'b1);
      for (int l = 0; l < fl; l++) begin
         push(hdr_m(6'h2B, 16'(lb)), 4'hF, 1'b0);
         for (int i = 0; i < nin; i++) dq.push_back($urandom);
         c = 16'hFFFF;
         for (int i = 0; i < wcw; i++) begin
            w = (i < nin) ? dq[l*nin + i] : 32'h0;
            c = crc_m(c, w);
            push(w, 4'hF, 1'b0);
         end
         push({16'h0, c}, 4'h3, 1'b1);
      end
      push(hdr_m(DT_FE, short_wc()), 4'hF, 1'b1);
      for (int l = 0; l < fl; l++)
         for (int i = 0; i < nin; i++)
            drive_word(dq[l*nin + i], (l == 0 && i == 0), (i == nin - 1));
      vid.tvalid = 1'b0;
      wait_drain();
      chk("len_err_pulses", err_pulses, exp_err);
      exp_fnum  = (exp_fnum == 65535) ? 1 : exp_fnum + 1;
      rnd_ready = 0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[6];
      logic [31:0] spec_w[6];
      bit          seen;

      vecs[0] = '{16, 1, 4, 0, 0};
      vecs[1] = '{16, 1, 2, 0, 1};
      vecs[2] = '{8,  3, 2, 1, 0};
      vecs[3] = '{8,  2, 4, 0, 2};
      vecs[4] = '{4,  2, 1, 1, 0};
      vecs[5] = '{12, 2, 1, 1, 2};

      spec_w[0] = 32'h020000FF;
      spec_w[1] = 32'h72F3DCB9;
      spec_w[2] = 32'h5AB8D4BB;
      spec_w[3] = 32'h7CC275C8;
      spec_w[4] = 32'hDF05F881;
      spec_w[5] = 32'h010000FF;

      srst        = 1'b1;
      enable      = 1'b0;
      line_bytes  = 16'h0;
      frame_lines = 16'h0;
      vid.tvalid  = 1'b0;
      vid.tdata   = 32'h0;
      vid.tstrb   = 4'hF;
      vid.tuser   = 1'b0;
      vid.tlast   = 1'b0;
      pkt.tready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", pkt.tvalid, 0);
      chk("rst_tlast",  pkt.tlast, 0);
      chk("rst_tstrb",  pkt.tstrb, 0);
      chk("rst_tdata",  pkt.tdata, 0);
      chk("rst_vready", vid.tready, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_busy",   busy, 0);
      @(posedge clk);
      #1;
      srst   = 1'b0;
      mon_en = 1;

      chk("pkg_ecc_fe", csi2_ecc(24'h000001), 6'h07);

      // SOF presented while disabled must not start a frame.
      vid.tdata  = 32'h11223344;
      vid.tuser  = 1'b1;
      vid.tvalid = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (vid.tready || pkt.tvalid || busy) seen = 1;
      end
      chk("disabled_no_start", seen, 0);
      @(posedge clk);
      #1;
      vid.tvalid = 1'b0;

      // Reference line with a known CRC.
      enable      = 1'b1;
      line_bytes  = 16'd24;
      frame_lines = 16'd1;
`ifdef CSI2_TX_FRAME_CNT_EN
      push(hdr_m(DT_FS, short_wc()), 4'hF, 1'b1);
`else
      push(32'h00000000, 4'hF, 1'b1);
`endif
      push(hdr_m(6'h2B, 16'd24), 4'hF, 1'b0);
      for (int i = 0; i < 6; i++) push(spec_w[i], 4'hF, 1'b0);
      push(32'h000000F0, 4'h3, 1'b1);
`ifdef CSI2_TX_FRAME_CNT_EN
      push(hdr_m(DT_FE, short_wc()), 4'hF, 1'b1);
`else
      push(32'h07000001, 4'hF, 1'b1);
`endif
      err_pulses = 0;
      for (int i = 0; i < 6; i++) drive_word(spec_w[i], (i == 0), (i == 5));
      vid.tvalid = 1'b0;
      wait_drain();
      chk("spec_len_err", err_pulses, 0);
      exp_fnum = exp_fnum + 1;

      for (int v = 0; v < 6; v++)
         run_frame(vecs[v].lb, vecs[v].fl, vecs[v].nin, vecs[v].rnd, vecs[v].exp_err);

      // Stray non-SOF word in IDLE is swallowed with no output.
      drive_word(32'hDEADBEEF, 1'b0, 1'b1);
      vid.tvalid = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_drop_busy", busy, 0);

      // Reset while the third payload word is on the bus.
      @(posedge clk);
      #1;
      mon_en      = 0;
      line_bytes  = 16'd16;
      frame_lines = 16'd1;
      drive_word(32'hA0A0A0A0, 1'b1, 1'b0);
      drive_word(32'hA1A1A1A1, 1'b0, 1'b0);
      vid.tdata  = 32'hA2A2A2A2;
      vid.tuser  = 1'b0;
      vid.tlast  = 1'b0;
      srst       = 1'b1;
      @(posedge clk);
      #1;
      srst       = 1'b0;
      vid.tvalid = 1'b0;
      chk("midrst_tvalid", pkt.tvalid, 0);
      chk("midrst_busy", busy, 0);
      q.delete();
      exp_fnum = 1;
      mon_en   = 1;
      run_frame(8, 1, 2, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
